// File: rtl/watch_display_scan.sv
// Stopwatch display back-end: snapshot/freeze, 6-of-8 digit scan with a dark
// guard interval, leading-zero blanking, fixed decimal points, 7-seg decode.
module watch_display_scan #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic       lap,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       frozen
);

    localparam int unsigned PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned NDIG    = 6;
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [3:0]    snap [NDIG];

    logic          frozen_nxt_c;
    logic [3:0]    cur_c;
    logic [7:0]    lead_zero_c;
    logic [7:0]    an_nxt_c;
    logic [6:0]    seg_nxt_c;
    logic          dp_nxt_c;

    // Active-low {g,f,e,d,c,b,a} pattern; codes 10..15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // Freeze state after this edge; the snapshot loads only when it ends up unfrozen.
    assign frozen_nxt_c = frozen ^ lap;

    // Prescaler and digit index: one slot per SCAN_DIV cycles, idx cycles 0..5.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (pcnt == PW'(SCAN_DIV - 1)) begin
            pcnt <= '0;
            idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Snapshot register and freeze flag; reset wins over a coincident lap.
    always_ff @(posedge clk) begin
        if (rst) begin
            frozen <= 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                snap[k] <= '0;
            end
        end else begin
            frozen <= frozen_nxt_c;
            if (!frozen_nxt_c) begin
                snap[0] <= d0;
                snap[1] <= d1;
                snap[2] <= d2;
                snap[3] <= d3;
                snap[4] <= d4;
                snap[5] <= d5;
            end
        end
    end

    // Select the snapshot digit for the current slot.
    always_comb begin
        cur_c = '0;
        case (idx)
            3'd0:    cur_c = snap[0];
            3'd1:    cur_c = snap[1];
            3'd2:    cur_c = snap[2];
            3'd3:    cur_c = snap[3];
            3'd4:    cur_c = snap[4];
            3'd5:    cur_c = snap[5];
            default: cur_c = '0;
        endcase
    end

    // Leading-zero chain from the top digit down; digits 0 and 1 never qualify.
    always_comb begin
        lead_zero_c    = '0;
        lead_zero_c[5] = (snap[5] == 4'd0);
        lead_zero_c[4] = lead_zero_c[5] && (snap[4] == 4'd0);
        lead_zero_c[3] = lead_zero_c[4] && (snap[3] == 4'd0);
        lead_zero_c[2] = lead_zero_c[3] && (snap[2] == 4'd0);
    end

    // Next output state: dark during the guard window, else one anode lit.
    always_comb begin
        an_nxt_c  = 8'hFF;
        seg_nxt_c = SEG_OFF;
        dp_nxt_c  = 1'b1;
        if (pcnt >= PW'(GUARD)) begin
            an_nxt_c[idx] = 1'b0;
            seg_nxt_c     = (blank_lz && lead_zero_c[idx]) ? SEG_OFF : decode(cur_c);
            dp_nxt_c      = !((idx == 3'd1) || (idx == 3'd3));
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt_c;
            seg <= seg_nxt_c;
            dp  <= dp_nxt_c;
        end
    end

endmodule

// File: tb/tb_watch_display_scan.sv
// Scoreboard bench for watch_display_scan with SCAN_DIV = 8, GUARD = 2.
module tb_watch_display_scan;

    localparam int unsigned SD   = 8;
    localparam int unsigned GD   = 2;
    localparam int          WDOG = 5000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic       lap;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       frozen;

    watch_display_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
        .lap(lap), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .an(an), .frozen(frozen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frz;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   base = 0;
    int   ntag = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic done = 1'b0;
    logic ack = 1'b0;

    // Hand-derived active-low patterns for digits 0..9, plus dash and blank.
    logic [6:0] segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int t_at(int s, int p);
        return base + int'(SD) * s + p;
    endfunction

    task automatic push(input int c, input logic [7:0] a, input logic [6:0] s,
                        input logic d, input logic f);
        exp_t x;
        x.cyc = c; x.tag = ntag; x.an = a; x.seg = s; x.dp = d; x.frz = f;
        ntag++;
        q.push_back(x);
    endtask

    task automatic dark(input int c, input logic f);
        push(c, 8'hFF, BLANK, 1'b1, f);
    endtask

    task automatic lit(input int c, input int i, input logic [6:0] s, input logic f);
        logic [7:0] one;
        one = 8'h01;
        push(c, ~(one << i), s, (i == 1 || i == 3) ? 1'b0 : 1'b1, f);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every cycle is an output sample; compare against the queue head.
    always @(negedge clk) begin
        if (cyc > WDOG) begin
            $display("FAIL watchdog cyc=%0d exceeded limit %0d", cyc, WDOG);
            $fatal(1, "watchdog expired");
        end
        vectors++;
        if (an[7:6] !== 2'b11) begin
            miscompares++;
            $display("FAIL an_7_6 cyc=%0d got %b want 11", cyc, an[7:6]);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_chk%0d expected at cyc=%0d now %0d", e.tag, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            vectors++;
            if ({an, seg, dp, frozen} !== {e.an, e.seg, e.dp, e.frz}) begin
                miscompares++;
                $display("FAIL chk%0d cyc=%0d an got %h want %h seg got %b want %b dp got %b want %b frozen got %b want %b",
                         e.tag, cyc, an, e.an, seg, e.seg, dp, e.dp, frozen, e.frz);
            end
        end
        if (done && !ack) begin
            vectors++;
            if (q.size() != 0) begin
                miscompares++;
                $display("FAIL leftover got %0d pending want 0", q.size());
            end
            ack = 1'b1;
        end
    end

    initial begin
        rst = 1'b1; lap = 1'b0; blank_lz = 1'b0;
        d0 = 4'd0; d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; d5 = 4'd5;
        dark(2, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = cyc + 1;

        // Reset and scan: slot s shows digit s; dark for the first two cycles.
        for (int s = 0; s < 6; s++) begin
            dark(t_at(s, 0), 1'b0);
            dark(t_at(s, 1), 1'b0);
            lit(t_at(s, 2), s, segt[s], 1'b0);
            lit(t_at(s, 7), s, segt[s], 1'b0);
        end
        lit(t_at(6, 2), 0, segt[0], 1'b0);

        // Freeze on 7, change input to 2, unfreeze.
        lit(t_at(7, 3), 1, segt[1], 1'b0);
        lit(t_at(7, 4), 1, segt[1], 1'b1);
        lit(t_at(12, 2), 0, segt[7], 1'b1);
        lit(t_at(12, 7), 0, segt[7], 1'b1);
        dark(t_at(13, 1), 1'b0);
        lit(t_at(18, 2), 0, segt[2], 1'b0);
        wait_cyc(t_at(7, 0)); d0 = 4'd7;
        wait_cyc(t_at(7, 3)); lap = 1'b1;
        wait_cyc(t_at(7, 4)); lap = 1'b0;
        wait_cyc(t_at(7, 5)); d0 = 4'd2;
        wait_cyc(t_at(13, 0)); lap = 1'b1;
        wait_cyc(t_at(13, 1)); lap = 1'b0;

        // Leading-zero blanking: 0,0,0,0,0,3 then d4 = 1.
        lit(t_at(24, 2), 0, segt[3], 1'b0);
        lit(t_at(25, 2), 1, segt[0], 1'b0);
        lit(t_at(26, 2), 2, BLANK, 1'b0);
        lit(t_at(27, 2), 3, BLANK, 1'b0);
        lit(t_at(28, 2), 4, BLANK, 1'b0);
        lit(t_at(29, 2), 5, BLANK, 1'b0);
        lit(t_at(32, 4), 2, segt[0], 1'b0);
        lit(t_at(33, 4), 3, segt[0], 1'b0);
        lit(t_at(34, 4), 4, segt[1], 1'b0);
        lit(t_at(35, 4), 5, BLANK, 1'b0);
        wait_cyc(t_at(19, 0));
        blank_lz = 1'b1;
        d0 = 4'd3; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd0; d5 = 4'd0;
        wait_cyc(t_at(30, 0)); d4 = 4'd1;

        // Invalid codes show a dash and count as nonzero for blanking.
        lit(t_at(38, 3), 2, segt[0], 1'b0);
        lit(t_at(39, 3), 3, DASH, 1'b0);
        lit(t_at(40, 3), 4, BLANK, 1'b0);
        lit(t_at(44, 3), 2, DASH, 1'b0);
        lit(t_at(45, 3), 3, BLANK, 1'b0);
        wait_cyc(t_at(36, 0)); d4 = 4'd0; d3 = 4'd12; d2 = 4'd0;
        wait_cyc(t_at(42, 0)); d3 = 4'd0; d2 = 4'd12;

        // Latency: a change after edge n reaches seg at edge n+2.
        lit(t_at(49, 4), 1, segt[0], 1'b0);
        lit(t_at(49, 5), 1, segt[9], 1'b0);
        wait_cyc(t_at(49, 3)); d1 = 4'd9;

        // Reset mid-slot while frozen, coincident with a lap pulse.
        dark(t_at(51, 1), 1'b1);
        lit(t_at(52, 4), 4, BLANK, 1'b1);
        dark(t_at(52, 5), 1'b0);
        wait_cyc(t_at(51, 0)); lap = 1'b1;
        wait_cyc(t_at(51, 1)); lap = 1'b0;
        wait_cyc(t_at(52, 4)); rst = 1'b1; lap = 1'b1;
        wait_cyc(t_at(52, 5)); rst = 1'b0; lap = 1'b0;
        base = cyc + 1;
        dark(t_at(0, 0), 1'b0);
        dark(t_at(0, 1), 1'b0);
        lit(t_at(0, 2), 0, segt[3], 1'b0);
        lit(t_at(1, 2), 1, segt[9], 1'b0);

        wait_cyc(t_at(1, 6));
        done = 1'b1;
        wait (ack);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
